// File: rtl/pcm_fir_pkg.sv
// Shared constants and sample type for the PCM feeder and the FIR lane.
package pcm_fir_pkg;

  localparam int PCM_W  = 16;  // sample and result width
  localparam int ADDR_W = 9;   // sample-buffer address width (512 entries)
  localparam int DS_W   = 4;   // downsample ratio width

  typedef logic [PCM_W-1:0] pcm_t;

endpackage

// File: rtl/pcm_fir_feeder.sv
// Upstream feeder for fir_lane: accepts PCM samples over valid/ready, writes
// them into the lane's circular buffer at an auto-incrementing address, paces
// accepts with a minimum gap, triggers the lane every downsample-th sample and
// returns the lane's previous result as a one-cycle strobe.
module pcm_fir_feeder #(
  parameter int PCM_W  = pcm_fir_pkg::PCM_W,
  parameter int ADDR_W = pcm_fir_pkg::ADDR_W,
  parameter int DS_W   = pcm_fir_pkg::DS_W
) (
  input  logic              pcm_clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PCM_W-1:0]  s_data,
  input  logic [DS_W-1:0]   downsample,
  input  logic [7:0]        min_gap,
  input  logic              flush,
  output logic              pcm_in_wr,
  output logic [PCM_W-1:0]  pcm_in,
  output logic [ADDR_W-1:0] pcm_in_address,
  output logic              fir_start,
  input  logic [PCM_W-1:0]  pcm_out,
  output logic              m_valid,
  output logic [PCM_W-1:0]  m_data
);

  logic              accept;
  logic              start_hit;
  logic              capture;
  logic [DS_W-1:0]   ds_eff;
  logic [DS_W:0]     phase_inc;
  logic [7:0]        gap_load;

  logic [7:0]        gap_cnt_q, gap_cnt_d;
  logic [DS_W-1:0]   phase_q, phase_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              primed_q, primed_d;

  logic              pcm_in_wr_q, pcm_in_wr_d;
  logic [PCM_W-1:0]  pcm_in_q, pcm_in_d;
  logic [ADDR_W-1:0] pcm_in_address_q, pcm_in_address_d;
  logic              fir_start_q, fir_start_d;
  logic              m_valid_q, m_valid_d;
  logic [PCM_W-1:0]  m_data_q, m_data_d;

  // Handshake, effective ratio/gap and the start decision for this accept.
  always_comb begin
    s_ready   = rst_n & ~flush & (gap_cnt_q == 8'd0);
    accept    = s_valid & s_ready;
    ds_eff    = (downsample == '0) ? DS_W'(1) : downsample;
    gap_load  = (min_gap == 8'd0) ? 8'd0 : 8'(min_gap - 8'd1);
    phase_inc = {1'b0, phase_q} + {{DS_W{1'b0}}, 1'b1};
    start_hit = (phase_inc >= {1'b0, ds_eff});
    // The very first start after reset/flush has no earlier result to return.
    capture   = fir_start_q & primed_q & ~flush;
  end

  // Gap counter: loaded on accept, counts down to zero; flush clears it.
  always_comb begin
    // NOTE: every combinational block assigns its outputs a default first, so no latch can be inferred.
    gap_cnt_d = gap_cnt_q;
    if (flush)                  gap_cnt_d = 8'd0;
    else if (accept)            gap_cnt_d = gap_load;
    else if (gap_cnt_q != 8'd0) gap_cnt_d = gap_cnt_q - 8'd1;
  end

  // Phase counter: wraps to zero on every start.
  always_comb begin
    phase_d = phase_q;
    if (flush)       phase_d = '0;
    else if (accept) phase_d = start_hit ? '0 : phase_inc[DS_W-1:0];
  end

  // Write address: increments per accept, wraps naturally at the buffer size.
  always_comb begin
    addr_d = addr_q;
    if (flush)       addr_d = '0;
    else if (accept) addr_d = addr_q + ADDR_W'(1);
  end

  // Primed flag: set once the first start has gone out since reset/flush.
  always_comb begin
    primed_d = primed_q;
    if (flush)            primed_d = 1'b0;
    else if (fir_start_q) primed_d = 1'b1;
  end

  // Registered lane-write and result outputs.
  always_comb begin
    pcm_in_wr_d      = accept;
    pcm_in_d         = accept ? s_data : pcm_in_q;
    pcm_in_address_d = accept ? addr_q : pcm_in_address_q;
    fir_start_d      = accept & start_hit;
    m_valid_d        = capture;
    m_data_d         = capture ? pcm_out : m_data_q;
  end

  // State update with synchronous active-low reset.
  always_ff @(posedge pcm_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      gap_cnt_q        <= 8'd0;
      phase_q          <= '0;
      addr_q           <= '0;
      primed_q         <= 1'b0;
      pcm_in_wr_q      <= 1'b0;
      pcm_in_q         <= '0;
      pcm_in_address_q <= '0;
      fir_start_q      <= 1'b0;
      m_valid_q        <= 1'b0;
      m_data_q         <= '0;
    end else begin
      gap_cnt_q        <= gap_cnt_d;
      phase_q          <= phase_d;
      addr_q           <= addr_d;
      primed_q         <= primed_d;
      pcm_in_wr_q      <= pcm_in_wr_d;
      pcm_in_q         <= pcm_in_d;
      pcm_in_address_q <= pcm_in_address_d;
      fir_start_q      <= fir_start_d;
      m_valid_q        <= m_valid_d;
      m_data_q         <= m_data_d;
    end
  end

  assign pcm_in_wr      = pcm_in_wr_q;
  assign pcm_in         = pcm_in_q;
  assign pcm_in_address = pcm_in_address_q;
  assign fir_start      = fir_start_q;
  assign m_valid        = m_valid_q;
  assign m_data         = m_data_q;

endmodule

// File: tb/tb_pcm_fir_feeder.sv
// Self-checking bench for pcm_fir_feeder against a cycle-level behavioural model.
module tb_pcm_fir_feeder;

  logic        pcm_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic [3:0]  downsample = 4'd1;
  logic [7:0]  min_gap = 8'd1;
  logic        flush = 1'b0;
  logic        pcm_in_wr;
  logic [15:0] pcm_in;
  logic [8:0]  pcm_in_address;
  logic        fir_start;
  logic [15:0] pcm_out = '0;
  logic        m_valid;
  logic [15:0] m_data;

  always #5 pcm_clk = ~pcm_clk;

  pcm_fir_feeder dut (
    .pcm_clk        (pcm_clk),
    .rst_n          (rst_n),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .downsample     (downsample),
    .min_gap        (min_gap),
    .flush          (flush),
    .pcm_in_wr      (pcm_in_wr),
    .pcm_in         (pcm_in),
    .pcm_in_address (pcm_in_address),
    .fir_start      (fir_start),
    .pcm_out        (pcm_out),
    .m_valid        (m_valid),
    .m_data         (m_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Configuration applied at the next cycle's input-drive point.
  int cfg_ds  = 1;
  int cfg_gap = 1;

  // Reference model: expectations for the outputs during the current cycle.
  bit          e_wr, e_start, e_mv;
  logic [15:0] e_pcm, e_md;
  int          e_addr;
  // Model stream state, in terms of samples and cycle timestamps.
  int          n_acc, since_start, cyc, last_acc, gap_need;
  bit          gap_free = 1'b1;
  bit          primed_m;
  bit          accepted;
  // Observed pulse counters for per-scenario totals.
  int          wr_cnt, mv_cnt, start_cnt;

  task automatic clear_counts();
    wr_cnt = 0; mv_cnt = 0; start_cnt = 0;
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model past the edge.
  task automatic cycle(input bit v, input logic [15:0] d, input bit fl, input bit rn);
    bit rdy;
    int ds;
    @(negedge pcm_clk);
    s_valid = v; s_data = d; flush = fl; rst_n = rn;
    downsample = 4'(cfg_ds); min_gap = 8'(cfg_gap);
    pcm_out = 16'($urandom);
    #1;
    rdy = rn && !fl && (gap_free || (cyc - last_acc >= gap_need));
    check("s_ready", 32'(s_ready), 32'(rdy));
    check("pcm_in_wr", 32'(pcm_in_wr), 32'(e_wr));
    check("fir_start", 32'(fir_start), 32'(e_start));
    check("m_valid", 32'(m_valid), 32'(e_mv));
    if (e_wr) begin
      check("pcm_in", 32'(pcm_in), 32'(e_pcm));
      check("pcm_in_address", 32'(pcm_in_address), e_addr);
    end
    if (e_mv) check("m_data", 32'(m_data), 32'(e_md));
    wr_cnt    += int'(pcm_in_wr);
    mv_cnt    += int'(m_valid);
    start_cnt += int'(fir_start);

    accepted = v && rdy;
    if (!rn) begin
      e_wr = 0; e_start = 0; e_mv = 0; e_pcm = '0; e_md = '0; e_addr = 0;
      n_acc = 0; since_start = 0; primed_m = 0; gap_free = 1;
    end else if (fl) begin
      e_wr = 0; e_start = 0; e_mv = 0;
      n_acc = 0; since_start = 0; primed_m = 0; gap_free = 1;
    end else begin
      e_mv = 0;
      if (e_start) begin
        if (primed_m) begin e_mv = 1; e_md = pcm_out; end
        primed_m = 1;
      end
      e_wr = accepted;
      e_start = 0;
      if (accepted) begin
        e_pcm  = d;
        e_addr = n_acc % 512;
        n_acc++;
        ds = (downsample == 0) ? 1 : int'(downsample);
        if (since_start + 1 >= ds) begin e_start = 1; since_start = 0; end
        else since_start++;
        gap_free = 0;
        last_acc = cyc;
        gap_need = (min_gap == 0) ? 1 : int'(min_gap);
      end
    end
    cyc++;
  endtask

  // Present samples continuously until n are accepted; seq=1 sends 0,1,2,...
  task automatic run_stream(input int n, input bit seq, output int used);
    int idx, budget;
    logic [15:0] val;
    idx = 0; used = 0;
    budget = n * (cfg_gap + 2) + 20;
    val = seq ? 16'd0 : 16'($urandom);
    while (idx < n && used < budget) begin
      cycle(1'b1, val, 1'b0, 1'b1);
      used++;
      if (accepted) begin
        idx++;
        val = seq ? 16'(idx) : 16'($urandom);
      end
    end
    if (idx < n) check("stream_budget", idx, n);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 16'd0, 1'b0, 1'b1);
  endtask

  task automatic do_flush();
    cycle(1'b0, 16'd0, 1'b1, 1'b1);
  endtask

  initial begin
    int used;

    // Reset and initial values.
    cycle(1'b0, 16'd0, 1'b0, 1'b0);
    cycle(1'b0, 16'd0, 1'b0, 1'b0);
    check("rst_pcm_in", 32'(pcm_in), 0);
    check("rst_addr", 32'(pcm_in_address), 0);
    check("rst_m_data", 32'(m_data), 0);

    // Scenario 1: ds=1, gap=7, samples 0..19.
    cfg_ds = 1; cfg_gap = 7;
    clear_counts();
    run_stream(20, 1'b1, used);
    idle(10);
    check("s1_writes", wr_cnt, 20);
    check("s1_starts", start_cnt, 20);
    check("s1_mvalid", mv_cnt, 19);

    // Scenario 2: ds=2, gap=5, random data, fresh stream.
    do_flush();
    cfg_ds = 2; cfg_gap = 5;
    clear_counts();
    run_stream(20, 1'b0, used);
    idle(8);
    check("s2_writes", wr_cnt, 20);
    check("s2_starts", start_cnt, 10);
    check("s2_mvalid", mv_cnt, 9);

    // Scenario 3: gap=0, continuous stream of 600 with address wrap.
    do_flush();
    cfg_ds = 3; cfg_gap = 0;
    clear_counts();
    run_stream(600, 1'b0, used);
    idle(4);
    check("s3_cycles", used, 600);
    check("s3_writes", wr_cnt, 600);
    check("s3_starts", start_cnt, 200);

    // Scenario 4: flush with s_valid high after 5 writes.
    do_flush();
    cfg_ds = 2; cfg_gap = 1;
    run_stream(5, 1'b0, used);
    cycle(1'b1, 16'hAAAA, 1'b1, 1'b1);
    check("s4_flush_no_accept", 32'(accepted), 0);
    clear_counts();
    run_stream(4, 1'b0, used);
    idle(4);
    check("s4_starts", start_cnt, 2);
    check("s4_mvalid", mv_cnt, 1);

    // Scenario 5: downsample 4 -> 2 once phase has reached 3.
    do_flush();
    cfg_ds = 4; cfg_gap = 2;
    clear_counts();
    run_stream(3, 1'b0, used);
    check("s5_no_start_yet", start_cnt, 0);
    cfg_ds = 2;
    run_stream(5, 1'b0, used);
    idle(4);
    check("s5_starts", start_cnt, 3);

    // Scenario 6: reset while the gap counter holds 4.
    do_flush();
    cfg_ds = 1; cfg_gap = 5;
    run_stream(1, 1'b0, used);
    cycle(1'b0, 16'd0, 1'b0, 1'b0);
    cycle(1'b0, 16'd0, 1'b0, 1'b1);
    check("s6_pcm_in", 32'(pcm_in), 0);
    check("s6_addr", 32'(pcm_in_address), 0);
    check("s6_m_data", 32'(m_data), 0);
    check("s6_ready", 32'(s_ready), 1);
    clear_counts();
    run_stream(1, 1'b1, used);
    idle(2);
    check("s6_writes", wr_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard stop in case anything above stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: got stalled expected finish");
    $fatal(1, "timeout");
  end

endmodule
